// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side signal bundle between sram_axi_bridge and the SoC crossbar.
// Length/burst fields are tied off in the SoC wrapper and are not carried here.
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arsize, arvalid, rready,
        output awid, awaddr, awsize, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arsize, arvalid, rready,
        input  awid, awaddr, awsize, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Instruction/data SRAM-like channels to a single AXI3 master, one transaction outstanding.
// Optional response-error reporting: define SRAM_AXI_BRIDGE_RESP_ERR_EN.
//
// state   | meaning
// IDLE    | accepting a request (data has priority)
// RD_ADDR | AR channel valid, waiting for arready
// RD_DATA | rready high, waiting for read data
// WR_REQ  | AW and W valid, each drops after its own handshake
// WR_RESP | bready high, waiting for write response
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inst_req,
    input  logic [1:0]              inst_size,
    input  logic [31:0]             inst_addr,
    output logic                    inst_addr_ok,
    output logic                    inst_data_ok,
    output logic [31:0]             inst_rdata,
    input  logic                    data_req,
    input  logic                    data_wr,
    input  logic [1:0]              data_size,
    input  logic [31:0]             data_addr,
    input  logic [3:0]              data_wstrb,
    input  logic [31:0]             data_wdata,
    output logic                    data_addr_ok,
    output logic                    data_data_ok,
    output logic [31:0]             data_rdata,
    sram_axi_bridge_if.master       axi
`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    ,
    output logic                    bus_err,
    output logic [31:0]             bus_err_addr
`endif
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        src_data_q, src_data_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        resp_err;

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    logic        bus_err_q, bus_err_d;
    logic [31:0] bus_err_addr_q, bus_err_addr_d;
    logic        unused_axi_in;
    assign unused_axi_in = ^{axi.rid, axi.rlast, axi.bid};
`else
    logic        unused_axi_in;
    assign unused_axi_in = ^{axi.rid, axi.rlast, axi.bid, axi.rresp, axi.bresp, resp_err};
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        src_data_d   = src_data_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        resp_err     = 1'b0;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    addr_d       = data_addr;
                    size_d       = data_size;
                    wstrb_d      = data_wstrb;
                    wdata_d      = data_wdata;
                    src_data_d   = 1'b1;
                    state_d      = data_wr ? WR_REQ : RD_ADDR;
                end else if (inst_req) begin
                    inst_addr_ok = 1'b1;
                    addr_d       = inst_addr;
                    size_d       = inst_size;
                    src_data_d   = 1'b0;
                    state_d      = RD_ADDR;
                end
            end
            RD_ADDR: if (axi.arready) state_d = RD_DATA;
            RD_DATA: if (axi.rvalid) begin
                resp_err = (axi.rresp != 2'b00);
                if (src_data_q) begin
                    data_rdata_d = axi.rdata;
                    data_ok_d    = 1'b1;
                end else begin
                    inst_rdata_d = axi.rdata;
                    inst_ok_d    = 1'b1;
                end
                state_d = IDLE;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | axi.awready;
                w_done_d  = w_done_q | axi.wready;
                if (aw_done_d && w_done_d) state_d = WR_RESP;
            end
            WR_RESP: if (axi.bvalid) begin
                resp_err  = (axi.bresp != 2'b00);
                data_ok_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            src_data_q   <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            src_data_q   <= src_data_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    // Error pulse is registered alongside data_ok so the two line up.
    always_comb begin
        bus_err_d      = resp_err;
        bus_err_addr_d = resp_err ? addr_q : bus_err_addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_err_q      <= 1'b0;
            bus_err_addr_q <= '0;
        end else begin
            bus_err_q      <= bus_err_d;
            bus_err_addr_q <= bus_err_addr_d;
        end
    end

    assign bus_err      = bus_err_q;
    assign bus_err_addr = bus_err_addr_q;
`endif

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    assign axi.arid    = src_data_q ? DATA_ID : INST_ID;
    assign axi.araddr  = addr_q;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arvalid = (state_q == RD_ADDR);
    assign axi.rready  = (state_q == RD_DATA);
    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign axi.wid     = DATA_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign axi.wlast   = axi.wvalid;
    assign axi.bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the bench acts as the AXI slave cycle by cycle.
// Error-reporting checks run only when SRAM_AXI_BRIDGE_RESP_ERR_EN is defined.
module tb_sram_axi_bridge;
    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    logic        bus_err;
    logic [31:0] bus_err_addr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    sram_axi_bridge_if axi ();

    sram_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi.master)
`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
        ,
        .bus_err      (bus_err),
        .bus_err_addr (bus_err_addr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bid = 0; axi.bresp = 0; axi.bvalid = 0;
        cyc(); cyc();
        chk("rst_arvalid", 32'(axi.arvalid), 0);
        chk("rst_rready", 32'(axi.rready), 0);
        chk("rst_awvalid", 32'(axi.awvalid), 0);
        chk("rst_wvalid", 32'(axi.wvalid), 0);
        chk("rst_bready", 32'(axi.bready), 0);
        chk("rst_inst_ok", 32'(inst_data_ok), 0);
        chk("rst_data_ok", 32'(data_data_ok), 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        reset = 1'b0;

        // instruction fetch, slave ready at first opportunity
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC0_0000; axi.arready = 1;
        settle();
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
        chk("t1_data_addr_ok", 32'(data_addr_ok), 0);
        cyc();
        inst_req = 0; axi.rvalid = 1; axi.rdata = 32'h3C08_0001;
        settle();
        chk("t1_arvalid", 32'(axi.arvalid), 1);
        chk("t1_arid", 32'(axi.arid), 0);
        chk("t1_arsize", 32'(axi.arsize), 2);
        chk("t1_araddr", axi.araddr, 32'hBFC0_0000);
        cyc();
        chk("t1_rready", 32'(axi.rready), 1);
        chk("t1_ok_early", 32'(inst_data_ok), 0);
        cyc();
        axi.rvalid = 0;
        settle();
        chk("t1_inst_data_ok", 32'(inst_data_ok), 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C08_0001);
        chk("t1_data_ok_quiet", 32'(data_data_ok), 0);
        cyc();
        chk("t1_ok_one_cycle", 32'(inst_data_ok), 0);
        chk("t1_rdata_hold", inst_rdata, 32'h3C08_0001);

        // simultaneous inst and data load: data wins
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_1000;
        settle();
        chk("t2_data_addr_ok", 32'(data_addr_ok), 1);
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
        cyc();
        data_req = 0; axi.rvalid = 1; axi.rdata = 32'h1234_5678;
        settle();
        chk("t2_arid", 32'(axi.arid), 1);
        chk("t2_araddr", axi.araddr, 32'h8000_1000);
        chk("t2_no_addr_ok_rdaddr", 32'(inst_addr_ok), 0);
        cyc();
        chk("t2_no_addr_ok_rddata", 32'(inst_addr_ok), 0);
        cyc();
        axi.rvalid = 0;
        settle();
        chk("t2_data_data_ok", 32'(data_data_ok), 1);
        chk("t2_data_rdata", data_rdata, 32'h1234_5678);
        chk("t2_inst_ok_quiet", 32'(inst_data_ok), 0);
        chk("t2_inst_accepted", 32'(inst_addr_ok), 1);
        cyc();
        inst_req = 0; axi.rvalid = 1; axi.rdata = 32'h2402_0005;
        settle();
        chk("t2_inst_arid", 32'(axi.arid), 0);
        chk("t2_inst_araddr", axi.araddr, 32'hBFC0_0004);
        cyc();
        cyc();
        axi.rvalid = 0;
        settle();
        chk("t2_inst_data_ok", 32'(inst_data_ok), 1);
        chk("t2_inst_rdata", inst_rdata, 32'h2402_0005);
        chk("t2_data_rdata_hold", data_rdata, 32'h1234_5678);
        cyc();

        // byte store, awready two cycles ahead of wready
        axi.arready = 0;
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h8000_2003;
        data_wstrb = 4'b1000; data_wdata = 32'hAB00_0000;
        settle();
        chk("t3_data_addr_ok", 32'(data_addr_ok), 1);
        cyc();
        data_req = 0; axi.awready = 1;
        settle();
        chk("t3_awvalid", 32'(axi.awvalid), 1);
        chk("t3_wvalid", 32'(axi.wvalid), 1);
        chk("t3_wlast", 32'(axi.wlast), 1);
        chk("t3_arvalid", 32'(axi.arvalid), 0);
        chk("t3_awaddr", axi.awaddr, 32'h8000_2003);
        chk("t3_awsize", 32'(axi.awsize), 0);
        chk("t3_awid", 32'(axi.awid), 1);
        chk("t3_wid", 32'(axi.wid), 1);
        chk("t3_wstrb", 32'(axi.wstrb), 32'h8);
        chk("t3_wdata", axi.wdata, 32'hAB00_0000);
        cyc();
        axi.awready = 0;
        settle();
        chk("t3_awvalid_drop", 32'(axi.awvalid), 0);
        chk("t3_wvalid_held", 32'(axi.wvalid), 1);
        chk("t3_no_bready", 32'(axi.bready), 0);
        cyc();
        axi.wready = 1;
        settle();
        chk("t3_wvalid_held2", 32'(axi.wvalid), 1);
        chk("t3_awvalid_low", 32'(axi.awvalid), 0);
        cyc();
        axi.wready = 0; axi.bvalid = 1;
        settle();
        chk("t3_wvalid_drop", 32'(axi.wvalid), 0);
        chk("t3_wlast_drop", 32'(axi.wlast), 0);
        chk("t3_bready", 32'(axi.bready), 1);
        chk("t3_ok_early", 32'(data_data_ok), 0);
        cyc();
        axi.bvalid = 0;
        settle();
        chk("t3_data_data_ok", 32'(data_data_ok), 1);
        chk("t3_bready_drop", 32'(axi.bready), 0);
        cyc();
        chk("t3_ok_one_cycle", 32'(data_data_ok), 0);

        // store with joint AW/W handshake and slow response
        axi.awready = 1; axi.wready = 1;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_3000;
        data_wstrb = 4'hF; data_wdata = 32'h5555_AAAA;
        settle();
        chk("t4_data_addr_ok", 32'(data_addr_ok), 1);
        cyc();
        data_req = 0; inst_req = 1; inst_addr = 32'hBFC0_0008;
        settle();
        chk("t4_awvalid", 32'(axi.awvalid), 1);
        chk("t4_wvalid", 32'(axi.wvalid), 1);
        cyc();
        axi.awready = 0; axi.wready = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t4_bready_wait%0d", i), 32'(axi.bready), 1);
            chk($sformatf("t4_no_addr_ok%0d", i), 32'({inst_addr_ok, data_addr_ok}), 0);
            chk($sformatf("t4_no_data_ok%0d", i), 32'(data_data_ok), 0);
            cyc();
        end
        axi.bvalid = 1;
        settle();
        chk("t4_bready_final", 32'(axi.bready), 1);
        cyc();
        axi.bvalid = 0;
        settle();
        chk("t4_data_data_ok", 32'(data_data_ok), 1);
        chk("t4_inst_accepted", 32'(inst_addr_ok), 1);

        // reset while a fetch is in RD_DATA
        cyc();
        inst_req = 0; axi.arready = 1;
        cyc();
        chk("t5_rready_before", 32'(axi.rready), 1);
        reset = 1;
        settle();
        chk("t5_arvalid", 32'(axi.arvalid), 0);
        chk("t5_rready", 32'(axi.rready), 0);
        chk("t5_inst_rdata_clr", inst_rdata, 0);
        cyc();
        chk("t5_rready_edge", 32'(axi.rready), 0);
        chk("t5_inst_ok", 32'(inst_data_ok), 0);
        chk("t5_data_ok", 32'(data_data_ok), 0);
        reset = 0;
        cyc();
        inst_req = 1; inst_addr = 32'hBFC0_0010;
        settle();
        chk("t5_inst_addr_ok", 32'(inst_addr_ok), 1);
        cyc();
        inst_req = 0; axi.rvalid = 1; axi.rdata = 32'hDEAD_BEEF;
        settle();
        chk("t5_araddr", axi.araddr, 32'hBFC0_0010);
        cyc();
        cyc();
        axi.rvalid = 0;
        settle();
        chk("t5_inst_data_ok", 32'(inst_data_ok), 1);
        chk("t5_inst_rdata", inst_rdata, 32'hDEAD_BEEF);

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
        cyc();
        chk("t6_err_addr_rst", bus_err_addr, 0);
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1FAF_0000;
        settle();
        chk("t6_data_addr_ok", 32'(data_addr_ok), 1);
        cyc();
        data_req = 0; axi.rvalid = 1; axi.rdata = 32'h0; axi.rresp = 2'b10;
        cyc();
        chk("t6_no_err_early", 32'(bus_err), 0);
        cyc();
        axi.rvalid = 0; axi.rresp = 2'b00;
        settle();
        chk("t6_data_ok", 32'(data_data_ok), 1);
        chk("t6_bus_err", 32'(bus_err), 1);
        chk("t6_bus_err_addr", bus_err_addr, 32'h1FAF_0000);
        cyc();
        chk("t6_bus_err_pulse", 32'(bus_err), 0);
        chk("t6_err_addr_hold", bus_err_addr, 32'h1FAF_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
